// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_pkg : shared widths, ALU codes and the MEM/WB bundle type    |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // Only subtract has a dedicated code; every other encoding decodes as add.
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;
  localparam logic [3:0] ALU_OP_ADD = 4'b0010;

  localparam int MEMWB_RDATA_W = DATA_W;
  localparam int MEMWB_ALU_W   = DATA_W;
  localparam int MEMWB_WREG_W  = REG_ADDR_W;
  localparam int MEMWB_W       = MEMWB_RDATA_W + MEMWB_ALU_W + MEMWB_WREG_W + 3;

  typedef struct packed {
    logic [MEMWB_RDATA_W-1:0] read_data;
    logic [MEMWB_ALU_W-1:0]   alu_result;
    logic [MEMWB_WREG_W-1:0]  write_reg;
    logic                     reg_write;
    logic                     mem_to_reg;
    logic                     addr_error;
  } memwb_t;

  function automatic logic alu_op_is_sub(input logic [3:0] op);
    return (op == ALU_OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem : DEPTH x 32 data memory, synchronous write, async read  |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
module data_mem
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Combinational read sees the pre-edge word, giving read-before-write.
  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage : MIPS memory-access stage with MEM/WB register,         |
// |             stall/flush and bad-address suppression.               |
// |             Optional: MEM_ALIGN_CHECK_EN enables misaligned trap.  |
// | Rev 1.0   : initial release                                        |
// +------------------------------------------------------------------+
module mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  memToReg,
  input  logic                  regWrite,
  input  logic [DATA_W-1:0]     aluResult,
  input  logic [DATA_W-1:0]     writeData,
  input  logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     readDataWB,
  output logic [DATA_W-1:0]     aluResultWB,
  output logic [REG_ADDR_W-1:0] writeRegWB,
  output logic                  regWriteWB,
  output logic                  memToRegWB,
  output logic                  addrErrorWB
);

  logic [ADDR_W-1:0] w_index;
  logic              w_out_of_range;
  logic              w_misaligned;
  logic              w_bad_access;
  logic              w_store_en;
  logic [DATA_W-1:0] w_mem_rdata;
  memwb_t            w_memwb_next;
  memwb_t            r_memwb;

  assign w_index        = aluResult[ADDR_W+1:2];
  // Any upper bit set (including the sign bit) is out of range; no aliasing.
  assign w_out_of_range = |aluResult[DATA_W-1:ADDR_W+2];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = |aluResult[1:0];
`else
  logic w_unused_lsb;
  assign w_misaligned = 1'b0;
  assign w_unused_lsb = ^aluResult[1:0];
`endif

  assign w_bad_access = (memRead | memWrite) & (w_out_of_range | w_misaligned);
  assign w_store_en   = memWrite & ~stall & ~reset & ~flush & ~w_bad_access;

  data_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (w_store_en),
    .addr  (w_index),
    .wdata (writeData),
    .rdata (w_mem_rdata)
  );

  always_comb begin
    w_memwb_next            = '0;
    w_memwb_next.read_data  = (memRead & ~w_bad_access) ? w_mem_rdata : '0;
    w_memwb_next.alu_result = aluResult;
    w_memwb_next.write_reg  = writeReg;
    w_memwb_next.reg_write  = regWrite & ~w_bad_access;
    w_memwb_next.mem_to_reg = memToReg;
    w_memwb_next.addr_error = w_bad_access;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_memwb <= '0;
    end else if (flush) begin
      r_memwb <= '0;
    end else if (!stall) begin
      r_memwb <= w_memwb_next;
    end
  end

  assign readDataWB  = r_memwb.read_data;
  assign aluResultWB = r_memwb.alu_result;
  assign writeRegWB  = r_memwb.write_reg;
  assign regWriteWB  = r_memwb.reg_write;
  assign memToRegWB  = r_memwb.mem_to_reg;
  assign addrErrorWB = r_memwb.addr_error;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Takes the ALU result as a word address or pass-through value, performs data-memory loads and stores, and registers everything the writeback stage needs into the MEM/WB pipeline register. It supports pipeline stall and flush, and flags bad addresses before they can corrupt memory or the register file.

## Interface
Parameters:
- DEPTH, 256: data memory size in 32-bit words; must be a power of two.
- ADDR_W, 8: word-index width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  holds the MEM/WB register and suppresses stores.
- flush  input  1  loads a bubble into the MEM/WB register.
- memRead  input  1  load request.
- memWrite  input  1  store request.
- memToReg  input  1  writeback selects memory data.
- regWrite  input  1  instruction writes the register file.
- aluResult  input  32  signed ALU output; byte address for loads and stores.
- writeData  input  32  store data (rt value).
- writeReg  input  5  destination register number.
- readDataWB  output  32  loaded word.
- aluResultWB  output  32  aluResult passed through.
- writeRegWB  output  5  destination register number.
- regWriteWB  output  1  register-file write enable.
- memToRegWB  output  1  writeback mux select.
- addrErrorWB  output  1  access was suppressed; valid for one cycle.

## Operation
- Word index is aluResult[ADDR_W+1:2].
- **Out of range:** an address is out of range when aluResult[31:ADDR_W+2] is nonzero. This covers negative signed results.
- **Misaligned:** an address is misaligned when aluResult[1:0] != 0. Checked only with MEM_ALIGN_CHECK_EN.
- **Bad access:** (memRead | memWrite) is asserted and the address is out of range or misaligned.
- **Store:** the word is written at the clk edge when memWrite & ~stall & ~reset & ~flush & no bad access.
- **Load:** data is read asynchronously from the array and captured into readDataWB at the edge.
- **Load with no read:** readDataWB = 0 when memRead is low or the access is bad.
- **memRead and memWrite both high:** the store proceeds; readDataWB captures the pre-write word (read-before-write).
- **Bad access:** no store; readDataWB = 0; regWriteWB forced 0; addrErrorWB = 1 for that slot.
- Memory contents are not reset.

## Timing
- Latency is one cycle from inputs to every *WB output.
- **Priority per edge:** reset > flush > stall > normal capture.
- **reset:** all *WB outputs go to 0 on the next edge. Any store presented in that cycle is dropped.
- **flush:** the MEM/WB register loads all-zero (a bubble) and any store is dropped. The flush applies even if stall is also high.
- **stall:** the MEM/WB register holds its value and the store is suppressed. The store executes on the first cycle in which stall is low, so exactly one write happens per instruction.
- **Reset mid-stall:** reset wins and the pending store is lost.
- **Address wrap:** none; any index ≥ DEPTH is an error, never aliased.
- **Back-to-back store then load to the same address:** the load in the next cycle returns the new data.

## Configuration
- MEM_ALIGN_CHECK_EN defined: the misalignment check described above is active.
- MEM_ALIGN_CHECK_EN undefined:
  - aluResult[1:0] is ignored and accesses use the word index only.
  - addrErrorWB is asserted only for out-of-range accesses.

## Structure
- Shared package mips_pkg holds:
  - DATA_W = 32 and REG_ADDR_W = 5;
  - ALU operation codes (4'b0110 sub; add as default);
  - the MEM/WB bundle field widths.
- Sub-module data_mem:
  - DEPTH × 32 array with synchronous write and asynchronous read;
  - ports: clk, we, addr[ADDR_W-1:0], wdata, rdata.
- mem_stage contains the address checks, the store gating and the MEM/WB register.

## Test plan
- **Store/load:** store 0xDEADBEEF to address 0x10, then load 0x10 in the next cycle. Expect readDataWB = 0xDEADBEEF, memToRegWB = 1, addrErrorWB = 0.
- **Stall:** store 0x1234 to 0x20 with stall high for 3 cycles. Expect the WB outputs held and no write. Then release the stall and load 0x20; expect 0x1234.
- **Flush:** store to 0x30 with flush and stall both high. Expect all-zero WB outputs and no store; a later load of 0x30 returns the prior contents.
- **Bad address:**
  - load from aluResult = -4: expect addrErrorWB = 1, regWriteWB = 0, readDataWB = 0;
  - with MEM_ALIGN_CHECK_EN, store to 0x22: expect addrErrorWB = 1 and memory unchanged.
- **Reset:** assert reset during a store to 0x40. Expect all outputs 0 after the edge and memory at 0x40 unchanged.
- **Pass-through:** an R-type instruction with aluResult = 0xFFFFFFF0, regWrite = 1, writeReg = 9. Expect aluResultWB = 0xFFFFFFF0, writeRegWB = 9, regWriteWB = 1, addrErrorWB = 0.
